branch_predictor_bht: RTL

- Downstream consumer of the execute-stage branch comparator result.
- Holds a direct-mapped table of 2-bit saturating counters. Fetch reads the table to predict direction.
- Execute writes the table with the resolved `taken` bit and the prediction carried down the pipe.
- On disagreement, issues a registered mispredict and redirect PC to the fetch/flush logic, and keeps a saturating mispredict count.

---
 rtl/branch_predictor_bht_pkg.sv | 22 ++
 rtl/branch_predictor_bht_if.sv | 38 +++
 rtl/branch_predictor_bht_sat_ctr.sv | 20 ++
 rtl/branch_predictor_bht.sv | 112 +++++++++++
 4 files changed

// File: rtl/branch_predictor_bht_pkg.sv
// rtl/branch_predictor_bht_pkg.sv - shared types and constants for the branch history table
package branch_predictor_bht_pkg;

   // 2-bit saturating direction counter
   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_SNT = 2'b00;
   localparam bht_ctr_t BHT_WNT = 2'b01;
   localparam bht_ctr_t BHT_WT  = 2'b10;
   localparam bht_ctr_t BHT_ST  = 2'b11;

   // Weakly not-taken: one taken outcome flips the prediction
   localparam bht_ctr_t BHT_RESET_VAL = BHT_WNT;

   localparam int BHT_PC_W = 64;

   // Direction predicted by a counter is its upper bit
   function automatic logic bht_predict(input bht_ctr_t ctr);
      return ctr[1];
   endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// rtl/branch_predictor_bht_if.sv - lookup/update/redirect bundle between pipeline and predictor
interface branch_predictor_bht_if #(
   parameter int CNT_W = 32
);
   // fetch-side lookup
   logic             pred_valid_i;
   logic [63:0]      pred_pc_i;
   logic             pred_resp_valid_o;
   logic             pred_taken_o;
   // execute-side update
   logic             upd_valid_i;
   logic [63:0]      upd_pc_i;
   logic             upd_taken_i;
   logic             upd_pred_taken_i;
   logic [63:0]      upd_target_i;
   logic             flush_i;
   // redirect and statistics
   logic             mispredict_o;
   logic [63:0]      redirect_pc_o;
   logic [CNT_W-1:0] mispredict_cnt_o;

   // pipeline side
   modport master (
      output pred_valid_i, pred_pc_i,
      output upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_taken_i, upd_target_i, flush_i,
      input  pred_resp_valid_o, pred_taken_o,
      input  mispredict_o, redirect_pc_o, mispredict_cnt_o
   );

   // predictor side
   modport slave (
      input  pred_valid_i, pred_pc_i,
      input  upd_valid_i, upd_pc_i, upd_taken_i, upd_pred_taken_i, upd_target_i, flush_i,
      output pred_resp_valid_o, pred_taken_o,
      output mispredict_o, redirect_pc_o, mispredict_cnt_o
   );

endinterface

// File: rtl/branch_predictor_bht_sat_ctr.sv
// rtl/branch_predictor_bht_sat_ctr.sv - next state of one 2-bit saturating counter
module bht_sat_ctr
   import branch_predictor_bht_pkg::*;
(
   input  bht_ctr_t cur,
   input  logic     taken,
   output bht_ctr_t next
);

   // step toward the observed outcome, clamping at both ends
   always_comb begin
      next = cur;
      if (taken) begin
         if (cur != BHT_ST) next = cur + 2'd1;
      end else begin
         if (cur != BHT_SNT) next = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - direct-mapped 2-bit counter predictor with mispredict redirect
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   branch_predictor_bht_if.slave bus
);

   localparam int IDX_W = $clog2(ENTRIES);

   bht_ctr_t         ctr_q [ENTRIES];
   logic             resp_valid_q;
   logic             pred_taken_q;
   logic             mispredict_q;
   logic [63:0]      redirect_pc_q;
   logic [CNT_W-1:0] mis_cnt_q;

   logic [IDX_W-1:0] pred_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_accept;
   logic             mis_cond;
   bht_ctr_t         upd_cur;
   bht_ctr_t         upd_next;
   bht_ctr_t         pred_cur;
   bht_ctr_t         pred_bumped;
   bht_ctr_t         pred_eff;
   logic             unused_pc_bits;

   assign pred_idx   = bus.pred_pc_i[IDX_W+1:2];
   assign upd_idx    = bus.upd_pc_i[IDX_W+1:2];
   assign upd_accept = bus.upd_valid_i & ~bus.flush_i;
   assign mis_cond   = upd_accept & (bus.upd_taken_i != bus.upd_pred_taken_i);

   // only the word index within the table selects a counter
   assign unused_pc_bits = ^{bus.pred_pc_i[63:IDX_W+2], bus.pred_pc_i[1:0],
                             bus.upd_pc_i[1:0]};

   assign upd_cur  = ctr_q[upd_idx];
   assign pred_cur = ctr_q[pred_idx];

   bht_sat_ctr u_upd_ctr (
      .cur   (upd_cur),
      .taken (bus.upd_taken_i),
      .next  (upd_next)
   );

   // same-index update in this cycle is seen by the lookup (write-first)
   bht_sat_ctr u_byp_ctr (
      .cur   (pred_cur),
      .taken (bus.upd_taken_i),
      .next  (pred_bumped)
   );

   // select the counter the lookup should observe
   always_comb begin
      pred_eff = pred_cur;
      if (upd_accept && (upd_idx == pred_idx)) pred_eff = pred_bumped;
   end

   // counter table: reset to weakly not-taken, written by accepted updates
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_RESET_VAL;
      end else if (upd_accept) begin
         ctr_q[upd_idx] <= upd_next;
      end
   end

   // lookup response: one cycle after request, direction held while idle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         resp_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
      end else begin
         resp_valid_q <= bus.pred_valid_i;
         if (bus.pred_valid_i) pred_taken_q <= bht_predict(pred_eff);
      end
   end

   // mispredict pulse and redirect target, loaded only on disagreement
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mispredict_q  <= 1'b0;
         redirect_pc_q <= 64'd0;
      end else begin
         mispredict_q <= mis_cond;
         if (mis_cond) begin
            redirect_pc_q <= bus.upd_taken_i ? bus.upd_target_i : (bus.upd_pc_i + 64'd4);
         end
      end
   end

   // saturating mispredict statistics
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mis_cnt_q <= '0;
      end else if (mis_cond && (mis_cnt_q != {CNT_W{1'b1}})) begin
         mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
   end

   assign bus.pred_resp_valid_o = resp_valid_q;
   assign bus.pred_taken_o      = pred_taken_q;
   assign bus.mispredict_o      = mispredict_q;
   assign bus.redirect_pc_o     = redirect_pc_q;
   assign bus.mispredict_cnt_o  = mis_cnt_q;

endmodule
